pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the Lab-4 single-cycle RISC-V core.
- Consumes the next-PC value produced by the next-PC logic (PC+4 or PC+ImmOp, selected by PCsrc) and drives the current PC back to it.
- Issues fetch requests to instruction memory with a valid/ready handshake, captures the returned word, and hands the instruction and its PC to decode with a valid/ready handshake.

Parameters:
- WIDTH, 32, address/PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- next_pc  in  WIDTH  next-PC value from the next-PC logic, combinational function of pc.
- stall  in  1  hold the current instruction; blocks PC advance.
- pc  out  WIDTH  current PC register; feeds the next-PC logic.
- req_valid  out  1  fetch request valid to instruction memory.
- req_ready  in  1  instruction memory accepts the request.
- req_addr  out  WIDTH  fetch address; always equal to pc.
- rsp_valid  in  1  instruction memory response valid.
- rsp_data  in  32  fetched instruction word.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode consumes the instruction.
- instr  out  32  held instruction word.
- instr_pc  out  WIDTH  PC of the held instruction; equals pc while instr_valid=1.
- misalign_err  out  1  sticky misaligned-PC flag; tied to 0 when MISALIGN_TRAP_EN is undefined.

Behaviour:
- Reset (asynchronous, any state, including mid-request or mid-response):
  - pc=RESET_PC, state=IDLE.
  - req_valid=0, instr_valid=0, instr=0, misalign_err=0.
  - An outstanding memory response is discarded.
- States: IDLE, REQ, WAIT, HOLD, plus TRAP (only when MISALIGN_TRAP_EN is defined).
- IDLE:
  - Unconditionally moves to REQ on the next edge.
  - First req_valid=1 appears in the 2nd cycle after rst deasserts.
- REQ:
  - req_valid=1, req_addr=pc.
  - On req_valid&&req_ready, go to WAIT.
  - While !req_ready, req_addr and req_valid stay stable.
- WAIT:
  - req_valid=0.
  - On rsp_valid, instr<=rsp_data, instr_valid<=1, go to HOLD.
  - rsp_valid in any state other than WAIT is ignored, including the same cycle as request acceptance.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable.
  - If instr_ready && !stall: pc<=next_pc, instr_valid<=0, go to REQ.
  - Otherwise remain in HOLD.
  - stall=1 overrides instr_ready=1.
- PC update rule: pc changes only on the HOLD advance edge (or reset).
- Throughput: with zero-wait memory (req_ready=1, rsp_valid one cycle after accept) and instr_ready=1, one instruction every 3 cycles.
- Arithmetic: none internally. next_pc wraps naturally in the external adder; 32'hFFFF_FFFC+4 arriving as 0 is accepted as-is.
- req_addr is combinationally equal to pc.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - On the HOLD advance edge, if next_pc[1:0]!=0: pc<=next_pc unmodified, misalign_err<=1 (sticky until rst), go to TRAP.
  - TRAP: req_valid=0 and instr_valid=0 permanently until reset.
- Undefined:
  - pc<={next_pc[WIDTH-1:2],2'b00}; misaligned low bits are silently forced to zero.
  - misalign_err is held at 0; no TRAP state.

Test Plan:
- Reset release, RESET_PC=0, memory always ready with 1-cycle response, instr_ready=1, next_pc=pc+4 → req_addr sequence 0x0, 0x4, 0x8; instr_valid pulses once every 3 cycles; first req_valid=1 in the 2nd cycle after rst falls.
- req_ready held 0 for 4 cycles in REQ with pc=0x10 → req_valid=1 and req_addr=0x10 stable for all 5 cycles; exactly one accept; no extra state advance.
- In HOLD with instr=0x00500093, pc=0x8: stall=1 and instr_ready=1 for 3 cycles, then stall=0 → pc stays 0x8, instr stays 0x00500093 during the stall; pc becomes next_pc (e.g. branch target 0x20) on the release edge.
- Spurious rsp_valid=1 with rsp_data=0xDEADBEEF while in REQ or HOLD → instr unchanged; no state change.
- rst asserted mid-WAIT (outstanding request at 0x14), then a late rsp_valid arrives → pc=0, instr_valid=0, instr=0 immediately; the late response is ignored; fetch restarts at 0x0.
- next_pc=0x22 on advance: with MISALIGN_TRAP_EN defined → misalign_err=1, pc=0x22, no further req_valid; without it → pc=0x20 and the fetch issues at 0x20.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and instruction-fetch sequencer (IDLE/REQ/WAIT/HOLD[/TRAP]).
// Latency: accept -> instr_valid after 2 edges; 3 cycles per instruction with zero-wait memory.
// Backpressure: req held stable while !req_ready; instr held in HOLD while !instr_ready or stall.
// Optional: define MISALIGN_TRAP_EN to trap on a misaligned next_pc instead of truncating it.
module pc_fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] next_pc,
   input  logic             stall,
   output logic [WIDTH-1:0] pc,
   output logic             req_valid,
   input  logic             req_ready,
   output logic [WIDTH-1:0] req_addr,
   input  logic             rsp_valid,
   input  logic [31:0]      rsp_data,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [31:0]      instr,
   output logic [WIDTH-1:0] instr_pc,
   output logic             misalign_err
);

`ifdef MISALIGN_TRAP_EN
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD, ST_TRAP} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic             advance;

   // decode hands off the held word only when it is ready and the core is not stalled
   assign advance = instr_ready && !stall;

`ifdef MISALIGN_TRAP_EN
   logic err_q, err_d;

   // sticky misalignment flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign misalign_err = err_q;
`else
   // the two low next_pc bits are dropped on purpose: the PC is forced word-aligned
   logic unused_np_lsb;
   assign unused_np_lsb = ^next_pc[1:0];
   assign misalign_err  = 1'b0;
`endif

   // state, PC and instruction registers; reset also drops any outstanding response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // next-state logic; the PC only moves on the HOLD advance edge
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
`ifdef MISALIGN_TRAP_EN
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // responses are only meaningful here; elsewhere rsp_valid is ignored
            if (rsp_valid) begin
               instr_d = rsp_data;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (advance) begin
`ifdef MISALIGN_TRAP_EN
               pc_d = next_pc;
               if (next_pc[1:0] != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = ST_TRAP;
               end else begin
                  state_d = ST_REQ;
               end
`else
               pc_d    = {next_pc[WIDTH-1:2], 2'b00};
               state_d = ST_REQ;
`endif
            end
         end
`ifdef MISALIGN_TRAP_EN
         ST_TRAP: state_d = ST_TRAP;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // handshake outputs are pure functions of the current state
   always_comb begin
      req_valid   = (state_q == ST_REQ);
      instr_valid = (state_q == ST_HOLD);
   end

   assign pc       = pc_q;
   assign req_addr = pc_q;
   assign instr    = instr_q;
   assign instr_pc = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit.
// Accepted fetches push {addr, word}; decode handshakes pop and compare instr/instr_pc.
// Memory model answers one cycle after accept; stalls and spurious responses are injected inline.
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] next_pc;
   logic        stall;
   logic [31:0] pc;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        misalign_err;

   logic        np_ovr_en;
   logic [31:0] np_ovr;

   int          n_total;
   int          n_bad;
   int          n_acc;
   logic [63:0] sb[$];

   pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst          (rst),
      .next_pc      (next_pc),
      .stall        (stall),
      .pc           (pc),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .misalign_err (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // external next-PC logic: PC+4 unless a branch target is forced
   always_comb begin
      next_pc = np_ovr_en ? np_ovr : pc + 32'd4;
   end

   function automatic logic [31:0] data_of(input logic [31:0] a);
      if (a == 32'h8) return 32'h0050_0093;
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // one clock: scoreboard push/pop on handshakes, then memory answers an accept one cycle later
   task automatic tick();
      logic        acc;
      logic        hs;
      logic [31:0] a;
      logic [63:0] e;
      acc = req_valid && req_ready && !rst;
      hs  = instr_valid && instr_ready && !stall && !rst;
      a   = req_addr;
      if (acc) begin
         sb.push_back({a, data_of(a)});
         n_acc++;
      end
      if (hs) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("sb_instr", instr, e[31:0]);
            check("sb_instr_pc", instr_pc, e[63:32]);
         end
      end
      @(posedge clk);
      #1;
      rsp_valid = acc;
      rsp_data  = acc ? data_of(a) : 32'h0;
   endtask

   initial begin
      int acc_base;
      n_total = 0; n_bad = 0; n_acc = 0;
      rst = 1'b1; stall = 1'b0; req_ready = 1'b1; instr_ready = 1'b1;
      rsp_valid = 1'b0; rsp_data = 32'h0; np_ovr_en = 1'b0; np_ovr = 32'h0;
      @(posedge clk); @(posedge clk); #1;

      // reset state
      check("rst_pc", pc, 32'h0);
      check("rst_req_valid", {31'h0, req_valid}, 32'h0);
      check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_misalign", {31'h0, misalign_err}, 32'h0);

      // release: IDLE for one cycle, first request in the second
      rst = 1'b0;
      check("idle_req_valid", {31'h0, req_valid}, 32'h0);
      tick();
      check("first_req_valid", {31'h0, req_valid}, 32'h1);

      // sequential fetch 0x0, 0x4 with one instruction per 3 cycles
      for (int i = 0; i < 2; i++) begin
         check("seq_req_valid", {31'h0, req_valid}, 32'h1);
         check("seq_req_addr", req_addr, 32'(4 * i));
         tick();
         check("wait_req_valid", {31'h0, req_valid}, 32'h0);
         check("wait_instr_valid", {31'h0, instr_valid}, 32'h0);
         tick();
         check("hold_instr_valid", {31'h0, instr_valid}, 32'h1);
         tick();
      end

      // fetch at 0x8, then stall in HOLD with a spurious response mid-stall
      check("seq_req_addr8", req_addr, 32'h8);
      stall = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         check("stall_pc", pc, 32'h8);
         check("stall_instr", instr, 32'h0050_0093);
         check("stall_instr_valid", {31'h0, instr_valid}, 32'h1);
         if (k == 1) begin
            rsp_valid = 1'b1;
            rsp_data  = 32'hDEAD_BEEF;
         end
         tick();
      end
      stall = 1'b0; np_ovr = 32'h20; np_ovr_en = 1'b1;
      tick();
      np_ovr_en = 1'b0;
      check("branch_pc", pc, 32'h20);
      check("branch_req_valid", {31'h0, req_valid}, 32'h1);

      // spurious response while in REQ with memory not ready
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
      tick();
      check("spur_req_valid", {31'h0, req_valid}, 32'h1);
      check("spur_req_addr", req_addr, 32'h20);
      check("spur_instr", instr, 32'h0050_0093);
      check("spur_instr_valid", {31'h0, instr_valid}, 32'h0);
      req_ready = 1'b1;
      tick();
      tick();
      check("hold20_instr_valid", {31'h0, instr_valid}, 32'h1);
      np_ovr = 32'h10; np_ovr_en = 1'b1;
      tick();
      np_ovr_en = 1'b0;

      // memory backpressure: 4 not-ready cycles then one accept at 0x10
      req_ready = 1'b0;
      acc_base  = n_acc;
      for (int k = 0; k < 4; k++) begin
         check("bp_req_valid", {31'h0, req_valid}, 32'h1);
         check("bp_req_addr", req_addr, 32'h10);
         tick();
      end
      req_ready = 1'b1;
      check("bp_req_valid5", {31'h0, req_valid}, 32'h1);
      check("bp_req_addr5", req_addr, 32'h10);
      tick();
      check("bp_accepts", 32'(n_acc - acc_base), 32'd1);
      check("bp_wait_req_valid", {31'h0, req_valid}, 32'h0);
      tick();
      check("bp_hold_instr", instr, 32'hC0DE_0010);
      np_ovr = 32'h14; np_ovr_en = 1'b1;
      tick();
      np_ovr_en = 1'b0;
      check("req14_addr", req_addr, 32'h14);
      tick();

      // reset in WAIT with a response outstanding, then a late response
      rst = 1'b1;
      #1;
      check("mid_rst_pc", pc, 32'h0);
      check("mid_rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      check("mid_rst_instr", instr, 32'h0);
      check("mid_rst_req_valid", {31'h0, req_valid}, 32'h0);
      sb.delete();
      tick();
      rst = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
      check("late_idle_instr", instr, 32'h0);
      tick();
      check("late_instr", instr, 32'h0);
      check("restart_pc", pc, 32'h0);
      check("restart_req_valid", {31'h0, req_valid}, 32'h1);
      check("restart_req_addr", req_addr, 32'h0);
      tick();
      tick();
      check("restart_instr", instr, 32'hC0DE_0000);

      // misaligned next_pc on advance
      np_ovr = 32'h22; np_ovr_en = 1'b1;
      tick();
      np_ovr_en = 1'b0;
`ifdef MISALIGN_TRAP_EN
      check("trap_pc", pc, 32'h22);
      check("trap_err", {31'h0, misalign_err}, 32'h1);
      for (int k = 0; k < 3; k++) begin
         check("trap_req_valid", {31'h0, req_valid}, 32'h0);
         check("trap_instr_valid", {31'h0, instr_valid}, 32'h0);
         tick();
      end
      check("trap_err_sticky", {31'h0, misalign_err}, 32'h1);
      sb.delete();
`else
      check("align_pc", pc, 32'h20);
      check("align_req_valid", {31'h0, req_valid}, 32'h1);
      check("align_req_addr", req_addr, 32'h20);
      check("align_err", {31'h0, misalign_err}, 32'h0);
      tick();
      tick();
      check("align_instr_pc", instr_pc, 32'h20);
      tick();
      check("sb_drained", 32'(sb.size()), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
